// File: rtl/alu_arbiter_seq_if.sv
// Bus bundle between the two requesting controllers and the shared ALU arbiter.
// The master side drives requests and operands; the slave side returns grant and result.
interface alu_arbiter_seq_if #(
   parameter int W = 16
);
   logic [1:0]     REQ;
   logic [W-1:0]   A0;
   logic [W-1:0]   B0;
   logic [3:0]     OP0;
   logic [W-1:0]   A1;
   logic [W-1:0]   B1;
   logic [3:0]     OP1;
   logic [1:0]     GNT;
   logic           BUSY;
   logic           DONE;
   logic           DONE_ID;
   logic [2*W-1:0] OUT;
   logic [1:0]     ERR;

   modport master (
      output REQ, A0, B0, OP0, A1, B1, OP1,
      input  GNT, BUSY, DONE, DONE_ID, OUT, ERR
   );

   modport slave (
      input  REQ, A0, B0, OP0, A1, B1, OP1,
      output GNT, BUSY, DONE, DONE_ID, OUT, ERR
   );
endinterface

// File: rtl/alu_arbiter_seq.sv
// Shared multi-cycle ALU with round-robin arbitration between two requesters.
// ADD/SUB finish in one EXEC cycle; MUL (shift-add) and DIV/MOD (restoring) take W cycles.
module alu_arbiter_seq #(
   parameter int W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   alu_arbiter_seq_if.slave bus
);

   localparam int            CW      = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST_IT = CW'(W - 1);
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_MOD = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic           last_q, last_d;
   logic           owner_q, owner_d;
   logic [3:0]     op_q, op_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   opa_q, opa_d;
   logic [W-1:0]   opb_q, opb_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [1:0]     gnt_q, gnt_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           done_id_q, done_id_d;
   logic [2*W-1:0] out_q, out_d;
   logic [1:0]     err_q, err_d;

   logic [W:0]     rem_shift_s;
   logic [W:0]     trial_s;
   logic           div_ok_s;
   logic [W-1:0]   rem_nxt_s;
   logic [W-1:0]   quo_nxt_s;
   logic [2*W-1:0] mul_acc_s;
   logic           div_zero_s;
   logic           iter_s;
   logic           finish_s;
   logic [2*W-1:0] res_s;
   logic [1:0]     err_s;
   logic           win_s;

   function automatic logic pick_winner(input logic [1:0] req, input logic last);
      logic win;
      case (req)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last;
         default: win = 1'b0;
      endcase
      return win;
   endfunction

   // Iteration datapath and the result that would be committed on this edge.
   always_comb begin
      rem_shift_s = {rem_q, opa_q[W-1]};
      trial_s     = rem_shift_s - {1'b0, opb_q};
      div_ok_s    = ~trial_s[W];
      rem_nxt_s   = div_ok_s ? trial_s[W-1:0] : rem_shift_s[W-1:0];
      quo_nxt_s   = {opa_q[W-2:0], div_ok_s};
      mul_acc_s   = opb_q[0] ? (acc_q + mcand_q) : acc_q;
      div_zero_s  = (opb_q == {W{1'b0}});
      res_s       = {(2*W){1'b0}};
      err_s       = 2'b00;
      iter_s      = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_s = {{W{1'b0}}, opa_q} + {{W{1'b0}}, opb_q};
         end
         OP_SUB: begin
            res_s = {{W{1'b0}}, opa_q} - {{W{1'b0}}, opb_q};
            err_s = {1'b0, (opa_q < opb_q)};
         end
         OP_MUL: begin
            res_s  = mul_acc_s;
            iter_s = 1'b1;
         end
         OP_DIV: begin
            res_s  = div_zero_s ? {(2*W){1'b0}} : {{W{1'b0}}, quo_nxt_s};
            err_s  = div_zero_s ? 2'b10 : 2'b00;
            iter_s = ~div_zero_s;
         end
         OP_MOD: begin
            res_s  = div_zero_s ? {(2*W){1'b0}} : {{W{1'b0}}, rem_nxt_s};
            err_s  = div_zero_s ? 2'b10 : 2'b00;
            iter_s = ~div_zero_s;
         end
         default: begin
            res_s = {(2*W){1'b0}};
         end
      endcase
      finish_s = ~iter_s | (cnt_q == LAST_IT);
      win_s    = pick_winner(bus.REQ, last_q);
   end

   // Next-state logic: arbitration in IDLE, one iteration per EXEC edge, one-cycle DONE.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      gnt_d     = 2'b00;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      out_d     = out_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.REQ != 2'b00) begin
               owner_d = win_s;
               last_d  = win_s;
               gnt_d   = win_s ? 2'b10 : 2'b01;
               busy_d  = 1'b1;
               state_d = S_EXEC;
               cnt_d   = {CW{1'b0}};
               opa_d   = win_s ? bus.A1 : bus.A0;
               opb_d   = win_s ? bus.B1 : bus.B0;
               op_d    = win_s ? bus.OP1 : bus.OP0;
               mcand_d = {{W{1'b0}}, (win_s ? bus.A1 : bus.A0)};
               acc_d   = {(2*W){1'b0}};
               rem_d   = {W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + CNT_ONE;
            case (op_q)
               OP_MUL: begin
                  acc_d   = mul_acc_s;
                  mcand_d = {mcand_q[2*W-2:0], 1'b0};
                  opb_d   = {1'b0, opb_q[W-1:1]};
               end
               OP_DIV, OP_MOD: begin
                  if (iter_s) begin
                     opa_d = quo_nxt_s;
                     rem_d = rem_nxt_s;
                  end else begin
                     rem_d = rem_q;
                  end
               end
               default: begin
                  acc_d = acc_q;
               end
            endcase
            if (finish_s) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               done_id_d = owner_q;
               out_d     = res_s;
               err_d     = err_s;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight command.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         op_q      <= 4'b0000;
         cnt_q     <= {CW{1'b0}};
         opa_q     <= {W{1'b0}};
         opb_q     <= {W{1'b0}};
         mcand_q   <= {(2*W){1'b0}};
         acc_q     <= {(2*W){1'b0}};
         rem_q     <= {W{1'b0}};
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         out_q     <= {(2*W){1'b0}};
         err_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         out_q     <= out_d;
         err_q     <= err_d;
      end
   end

   assign bus.GNT     = gnt_q;
   assign bus.BUSY    = busy_q;
   assign bus.DONE    = done_q;
   assign bus.DONE_ID = done_id_q;
   assign bus.OUT     = out_q;
   assign bus.ERR     = err_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Self-checking bench for alu_arbiter_seq: directed cases plus randomized commands
// compared against a plain-arithmetic reference model.
module tb_alu_arbiter_seq;

   localparam int W = 16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic m_last;

   alu_arbiter_seq_if #(.W(W)) bus ();

   alu_arbiter_seq #(.W(W)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] o, output logic [1:0] e, output int l);
      logic [2*W-1:0] ax, bx;
      ax = {{W{1'b0}}, a};
      bx = {{W{1'b0}}, b};
      o = '0;
      e = 2'b00;
      l = 1;
      case (op)
         4'h2: o = ax + bx;
         4'h3: begin o = ax - bx; e = {1'b0, (a < b)}; end
         4'h4: begin o = ax * bx; l = W; end
         4'h5: if (b == 0) e = 2'b10; else begin o = ax / bx; l = W; end
         4'h6: if (b == 0) e = 2'b10; else begin o = ax % bx; l = W; end
         default: o = '0;
      endcase
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge after DONE ends.
   task automatic do_cmd(input logic [1:0] req,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] op0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] op1,
                         input bit hold);
      logic           win;
      logic [W-1:0]   a, b;
      logic [3:0]     op;
      logic [2*W-1:0] eo;
      logic [1:0]     ee;
      int             el;
      int             lat;
      if (req == 2'b01)      win = 1'b0;
      else if (req == 2'b10) win = 1'b1;
      else                   win = (m_last == 1'b1) ? 1'b0 : 1'b1;
      m_last = win;
      a  = win ? a1 : a0;
      b  = win ? b1 : b0;
      op = win ? op1 : op0;
      model(op, a, b, eo, ee, el);
      bus.REQ = req;
      bus.A0 = a0; bus.B0 = b0; bus.OP0 = op0;
      bus.A1 = a1; bus.B1 = b1; bus.OP1 = op1;
      @(negedge clk);
      chk("gnt", bus.GNT, win ? 2'b10 : 2'b01);
      chk("busy_cap", bus.BUSY, 1'b1);
      chk("done_at_gnt", bus.DONE, 1'b0);
      if (!hold) bus.REQ = 2'b00;
      bus.A0 = W'($urandom); bus.B0 = W'($urandom); bus.OP0 = 4'($urandom);
      bus.A1 = W'($urandom); bus.B1 = W'($urandom); bus.OP1 = 4'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.DONE !== 1'b1) chk("gnt_exec", bus.GNT, 2'b00);
      end while (bus.DONE !== 1'b1 && lat < 40);
      chk("latency", lat, el);
      chk("out", bus.OUT, eo);
      chk("err", bus.ERR, ee);
      chk("done_id", bus.DONE_ID, win);
      chk("gnt_at_done", bus.GNT, 2'b00);
      chk("busy_done", bus.BUSY, 1'b1);
      @(negedge clk);
      chk("done_pulse", bus.DONE, 1'b0);
      chk("busy_idle", bus.BUSY, 1'b0);
      chk("out_held", bus.OUT, eo);
      chk("err_held", bus.ERR, ee);
   endtask

   initial begin
      logic [3:0] ops [8];
      int         seen;
      n_checks = 0;
      n_errors = 0;
      m_last   = 1'b1;
      ops = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h0, 4'hF, 4'h7};
      rst = 1'b1;
      bus.REQ = 2'b00;
      bus.A0 = '0; bus.B0 = '0; bus.OP0 = 4'h0;
      bus.A1 = '0; bus.B1 = '0; bus.OP1 = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", bus.GNT, 2'b00);
      chk("rst_busy", bus.BUSY, 1'b0);
      chk("rst_done", bus.DONE, 1'b0);
      chk("rst_id", bus.DONE_ID, 1'b0);
      chk("rst_out", bus.OUT, 32'h0);
      chk("rst_err", bus.ERR, 2'b00);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases from the plan.
      do_cmd(2'b01, 16'd11, 16'd51, 4'h2, 16'd0, 16'd0, 4'h0, 1'b0);
      do_cmd(2'b10, 16'd0, 16'd0, 4'h0, 16'd11, 16'd51, 4'h3, 1'b0);
      do_cmd(2'b01, 16'd62091, 16'd47411, 4'h4, 16'd0, 16'd0, 4'h0, 1'b0);
      do_cmd(2'b01, 16'd62091, 16'd47411, 4'h5, 16'd0, 16'd0, 4'h0, 1'b0);
      do_cmd(2'b01, 16'd62091, 16'd47411, 4'h6, 16'd0, 16'd0, 4'h0, 1'b0);
      do_cmd(2'b01, 16'd62091, 16'd47411, 4'h2, 16'd0, 16'd0, 4'h0, 1'b0);
      do_cmd(2'b01, 16'd11, 16'd0, 4'h5, 16'd0, 16'd0, 4'h0, 1'b0);
      do_cmd(2'b01, 16'd11, 16'd0, 4'h6, 16'd0, 16'd0, 4'h0, 1'b0);

      // Both requesting continuously must alternate starting with requester 0.
      apply_reset();
      for (int i = 0; i < 4; i++)
         do_cmd(2'b11, 16'd1, 16'd1, 4'h2, 16'd2, 16'd2, 4'h2, 1'b1);
      bus.REQ = 2'b00;
      @(negedge clk);
      @(negedge clk);

      // Reset in the middle of a multiply.
      bus.REQ = 2'b01; bus.A0 = 16'd62091; bus.B0 = 16'd47411; bus.OP0 = 4'h4;
      @(negedge clk);
      chk("mr_gnt", bus.GNT, 2'b01);
      bus.REQ = 2'b00;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1;
      chk("mr_gnt0", bus.GNT, 2'b00);
      chk("mr_busy", bus.BUSY, 1'b0);
      chk("mr_done", bus.DONE, 1'b0);
      chk("mr_id", bus.DONE_ID, 1'b0);
      chk("mr_out", bus.OUT, 32'h0);
      chk("mr_err", bus.ERR, 2'b00);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.DONE === 1'b1) seen++;
      end
      chk("mr_no_done", seen, 0);
      do_cmd(2'b11, 16'd5, 16'd6, 4'h2, 16'd7, 16'd8, 4'h2, 1'b0);

      // Randomized commands.
      for (int n = 0; n < 40; n++) begin
         logic [1:0]   rq;
         logic [W-1:0] ra0, rb0, ra1, rb1;
         logic [3:0]   ro0, ro1;
         rq  = 2'($urandom_range(1, 3));
         ra0 = W'($urandom);
         rb0 = ($urandom_range(0, 7) == 0) ? 16'd0 : W'($urandom);
         ra1 = W'($urandom);
         rb1 = ($urandom_range(0, 7) == 0) ? 16'd0 : W'($urandom);
         ro0 = ops[$urandom_range(0, 7)];
         ro1 = ops[$urandom_range(0, 7)];
         do_cmd(rq, ra0, rb0, ro0, ra1, rb1, ro1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
